pwm_duty_meter: RTL and testbench

Receive-side counterpart of the LED PWM generator. It samples an external PWM line, measures the period and high time between consecutive rising edges, and converts them to a 16-step duty level (0..15), the same scale the dimmer uses to drive it. It is used to loop back and check dimmer outputs, or to accept a PWM brightness command from an off-board source.

---
 rtl/pwm_duty_meter.sv | 203 ++++++++++++++++++++
 tb/tb_pwm_duty_meter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures period and high time of a PWM line and
// reports a 16-step duty level. Optional macro: PWM_GLITCH_FILTER_EN.
module pwm_duty_meter #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             pwm_in,
    output logic [3:0]       duty_level,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             valid,
    output logic             overrun,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        DIVIDE
    } state_t;

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_t           state;
    state_t           state_nx;
    logic             sync1;
    logic             sync2;
    logic             s_cur;
    logic             s_prev;
    logic             rise;
    logic             sat;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] cap_p;
    logic [CNT_W-1:0] cap_h;
    logic [CNT_W:0]   rem;
    logic [CNT_W:0]   rem_sh;
    logic [CNT_W:0]   rem_nx;
    logic [3:0]       quo;
    logic [3:0]       quo_nx;
    logic [1:0]       div_cnt;
    logic             armed;
    logic             do_capture;
    logic             do_timeout;
    logic             do_result;

    // Two-flop synchroniser plus the history flop used for edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            sync1  <= pwm_in;
            sync2  <= sync1;
            s_prev <= s_cur;
        end
    end

`ifdef PWM_GLITCH_FILTER_EN
    logic hist1;
    logic hist2;
    logic f_hold;

    // Last two synchronised samples and the held filtered level
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist1  <= 1'b0;
            hist2  <= 1'b0;
            f_hold <= 1'b0;
        end else begin
            hist1  <= sync2;
            hist2  <= hist1;
            f_hold <= s_cur;
        end
    end

    // Level follows the line only once three samples agree
    assign s_cur = (sync2 == hist1 && hist1 == hist2) ? sync2 : f_hold;
`else
    assign s_cur = sync2;
`endif

    assign rise = s_cur & ~s_prev;
    assign sat  = (period_cnt == TO_VAL);

    // Free-running period/high counters, restarted by every rising edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            period_cnt <= '0;
            high_cnt   <= '0;
        end else if (rise) begin
            period_cnt <= ONE;
            high_cnt   <= ONE;
        end else if (!sat) begin
            period_cnt <= period_cnt + ONE;
            high_cnt   <= high_cnt + {{(CNT_W-1){1'b0}}, s_cur};
        end
    end

    // One restoring-division step: shift, trial subtract, quotient bit
    always_comb begin
        rem_sh = rem << 1;
        rem_nx = rem_sh;
        quo_nx = {quo[2:0], 1'b0};
        if (rem_sh >= {1'b0, cap_p}) begin
            rem_nx = rem_sh - {1'b0, cap_p};
            quo_nx = {quo[2:0], 1'b1};
        end
    end

    // Next-state logic and one-cycle action strobes
    always_comb begin
        state_nx   = state;
        do_capture = 1'b0;
        do_timeout = 1'b0;
        do_result  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = MEASURE;
                end else if (sat && armed && !timeout) begin
                    do_timeout = 1'b1;
                end
            end
            MEASURE: begin
                if (rise) begin
                    do_capture = 1'b1;
                    state_nx   = DIVIDE;
                end else if (sat) begin
                    do_timeout = ~timeout;
                    state_nx   = IDLE;
                end
            end
            DIVIDE: begin
                if (div_cnt == 2'd3) begin
                    do_result = 1'b1;
                    state_nx  = MEASURE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register, capture of the finished period and divider datapath
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cap_p   <= '0;
            cap_h   <= '0;
            rem     <= '0;
            quo     <= '0;
            div_cnt <= '0;
            armed   <= 1'b0;
        end else begin
            state <= state_nx;
            if (do_capture) begin
                cap_p   <= period_cnt;
                cap_h   <= high_cnt;
                rem     <= {1'b0, high_cnt};
                quo     <= '0;
                div_cnt <= '0;
            end else if (state == DIVIDE) begin
                rem     <= rem_nx;
                quo     <= quo_nx;
                div_cnt <= div_cnt + 2'd1;
            end
            if (do_result) begin
                armed <= 1'b1;
            end
        end
    end

    // Output registers: results, stuck-line report and status pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            duty_level <= '0;
            period_out <= '0;
            high_out   <= '0;
            valid      <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            valid   <= do_result | do_timeout;
            overrun <= (state == DIVIDE) & rise;
            if (do_result) begin
                duty_level <= (cap_h == cap_p) ? 4'hF : quo_nx;
                period_out <= cap_p;
                high_out   <= cap_h;
                timeout    <= 1'b0;
            end else if (do_timeout) begin
                duty_level <= {4{s_cur}};
                period_out <= '0;
                high_out   <= '0;
                timeout    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// tb_pwm_duty_meter: directed and random PWM waveforms checked every cycle
// against an event-level model of the duty meter.
module tb_pwm_duty_meter;

    localparam int CNT_W = 16;
    localparam int TO    = 100;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b0;
    logic             pwm_in  = 1'b0;
    logic [3:0]       duty_level;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             valid;
    logic             overrun;
    logic             timeout;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;
    int ocnt   = 0;
    int tcnt   = 0;

    pwm_duty_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .pwm_in    (pwm_in),
        .duty_level(duty_level),
        .period_out(period_out),
        .high_out  (high_out),
        .valid     (valid),
        .overrun   (overrun),
        .timeout   (timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int any_out();
        return (duty_level != 0 || period_out != 0 || high_out != 0 ||
                valid || overrun || timeout) ? 1 : 0;
    endfunction

    // Model: result events scheduled at absolute cycle numbers
    typedef struct {
        int       at;
        int       d;
        int       p;
        int       h;
        bit       to;
    } res_t;

    res_t pend[$];
    int   ovr_at[$];
    int   cyc = 0;
    logic h1, h2, r1, r2, filt, m_prev;
    bit   have_ref, to_flag;
    int   last_rise, busy_until, hcount;
    int   e_d, e_p, e_h;
    bit   e_to, e_valid, e_ovr;

    task automatic model_clear();
        pend.delete();
        ovr_at.delete();
        h1 = 0; h2 = 0; r1 = 0; r2 = 0; filt = 0; m_prev = 0;
        have_ref = 0; to_flag = 0;
        last_rise = cyc; busy_until = 0; hcount = 0;
        e_d = 0; e_p = 0; e_h = 0; e_to = 0; e_valid = 0; e_ovr = 0;
    endtask

    // Advance the model one cycle and compare every output
    always @(negedge clock) begin
        logic raw, s, rise;
        int   k, p, h;
        res_t r;
        cyc++;
        if (!reset_n) begin
            model_clear();
            chk($sformatf("reset_outs@%0d", cyc), any_out(), 0);
        end else begin
            raw = h2; h2 = h1; h1 = pwm_in;
`ifdef PWM_GLITCH_FILTER_EN
            if (raw == r1 && r1 == r2) filt = raw;
            r2 = r1; r1 = raw;
            s = filt;
`else
            s = raw;
`endif
            e_valid = 0;
            e_ovr   = 0;
            if (pend.size() > 0 && pend[0].at == cyc) begin
                r = pend.pop_front();
                e_d = r.d; e_p = r.p; e_h = r.h; e_to = r.to;
                e_valid = 1;
            end
            if (ovr_at.size() > 0 && ovr_at[0] == cyc) begin
                void'(ovr_at.pop_front());
                e_ovr = 1;
            end
            rise = s && !m_prev;
            m_prev = s;
            k = cyc - last_rise;
            if (rise) begin
                if (have_ref && cyc <= busy_until) begin
                    ovr_at.push_back(cyc + 1);
                end else if (have_ref) begin
                    p = (k > TO) ? TO : k;
                    h = hcount;
                    r.at = cyc + 5;
                    r.p  = p;
                    r.h  = h;
                    r.d  = (h >= p) ? 15 : (16 * h) / p;
                    r.to = 0;
                    pend.push_back(r);
                    to_flag = 0;
                    busy_until = cyc + 4;
                end else begin
                    have_ref = 1;
                end
                last_rise = cyc;
                hcount = 1;
            end else begin
                if (k < TO) hcount += int'(s);
                if (have_ref && cyc > busy_until && k >= TO) begin
                    if (!to_flag) begin
                        r.at = cyc + 1;
                        r.d  = s ? 15 : 0;
                        r.p  = 0;
                        r.h  = 0;
                        r.to = 1;
                        pend.push_back(r);
                        to_flag = 1;
                    end
                    have_ref = 0;
                end
            end
            chk($sformatf("valid@%0d", cyc), int'(valid), int'(e_valid));
            chk($sformatf("overrun@%0d", cyc), int'(overrun), int'(e_ovr));
            chk($sformatf("duty@%0d", cyc), int'(duty_level), e_d);
            chk($sformatf("period@%0d", cyc), int'(period_out), e_p);
            chk($sformatf("high@%0d", cyc), int'(high_out), e_h);
            chk($sformatf("timeout@%0d", cyc), int'(timeout), int'(e_to));
            if (valid) vcnt++;
            if (overrun) ocnt++;
            if (valid && timeout) tcnt++;
        end
    end

    task automatic cycle_set(input logic v, input int n);
        repeat (n) begin
            @(posedge clock);
            #1 pwm_in = v;
        end
    endtask

    task automatic wave(input int hi, input int lo, input int reps);
        repeat (reps) begin
            cycle_set(1'b1, hi);
            cycle_set(1'b0, lo);
        end
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1 chk("reset_state", any_out(), 0);
        @(negedge clock);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clock);

        vcnt = 0; ocnt = 0;
        wave(4, 12, 5);
        chk("w4_12_period", int'(period_out), 16);
        chk("w4_12_high", int'(high_out), 4);
        chk("w4_12_duty", int'(duty_level), 4);
        chk("w4_12_model_p", e_p, 16);
        chk("w4_12_model_d", e_d, 4);
        chk("w4_12_valids", vcnt, 4);
        chk("w4_12_overruns", ocnt, 0);

        wave(15, 1, 3);
`ifndef PWM_GLITCH_FILTER_EN
        chk("w15_1_duty", int'(duty_level), 15);
        chk("w15_1_high", int'(high_out), 15);
`endif
        wave(1, 15, 3);
`ifndef PWM_GLITCH_FILTER_EN
        chk("w1_15_duty", int'(duty_level), 1);
        chk("w1_15_model_d", e_d, 1);
`endif

        wave(8, 8, 3);
        tcnt = 0;
        cycle_set(1'b1, 120);
        chk("stuck_to_valids", tcnt, 1);
        chk("stuck_timeout", int'(timeout), 1);
        chk("stuck_duty", int'(duty_level), 15);
        chk("stuck_period", int'(period_out), 0);
        wave(5, 5, 4);
        chk("recover_timeout", int'(timeout), 0);
        chk("recover_duty", int'(duty_level), 8);
        chk("recover_period", int'(period_out), 10);

        ocnt = 0;
        wave(1, 2, 8);
        cycle_set(1'b0, 10);
`ifndef PWM_GLITCH_FILTER_EN
        chk("short_overrun_seen", (ocnt >= 3) ? 1 : 0, 1);
        chk("short_period", int'(period_out), 3);
        chk("short_high", int'(high_out), 1);
        chk("short_duty", int'(duty_level), 5);
`endif

        wave(4, 12, 2);
        cycle_set(1'b1, 4);
        cycle_set(1'b0, 1);
        #1 reset_n = 1'b0;
        #1 chk("mid_divide_reset", any_out(), 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1 reset_n = 1'b1;
        vcnt = 0;
        wave(4, 12, 1);
        chk("post_reset_1rise", vcnt, 0);
        wave(4, 12, 1);
        chk("post_reset_2rise", vcnt, 1);
        chk("post_reset_high", int'(high_out), 4);

        wave(8, 8, 2);
        repeat (3) begin
            cycle_set(1'b1, 8);
            cycle_set(1'b0, 3);
            cycle_set(1'b1, 2);
            cycle_set(1'b0, 3);
        end
        wave(8, 8, 1);
`ifdef PWM_GLITCH_FILTER_EN
        chk("glitch_period", int'(period_out), 16);
        chk("glitch_high", int'(high_out), 8);
`else
        chk("glitch_period", int'(period_out), 5);
        chk("glitch_high", int'(high_out), 2);
`endif

        for (int i = 0; i < 40; i++) begin
            wave(int'($urandom_range(12, 1)), int'($urandom_range(12, 1)), 1);
        end
        cycle_set(1'b0, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
